// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
// Holds the default bus widths, the owner encoding and the grant function.
// The grant function is a pure function of the request and state inputs.
package dm_arb_pkg;

  localparam int unsigned DefAw = 6;
  localparam int unsigned DefDw = 32;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic   gnt;
    owner_e own;
  } grant_t;

  // Priority order: starvation override, host lock continuation,
  // single requester, then round-robin against the last owner.
  function automatic grant_t arb_pick(input logic   c_req,
                                      input logic   h_req,
                                      input logic   starve,
                                      input owner_e last_own,
                                      input logic   lock);
    grant_t g;
    g.gnt = 1'b0;
    g.own = last_own;
    if (starve) begin
      g.gnt = 1'b1;
      g.own = OWN_CPU;
    end else if (last_own == OWN_HOST && lock && h_req) begin
      g.gnt = 1'b1;
      g.own = OWN_HOST;
    end else if (c_req && h_req) begin
      g.gnt = 1'b1;
      g.own = (last_own == OWN_CPU) ? OWN_HOST : OWN_CPU;
    end else if (c_req) begin
      g.gnt = 1'b1;
      g.own = OWN_CPU;
    end else if (h_req) begin
      g.gnt = 1'b1;
      g.own = OWN_HOST;
    end
    return g;
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the CPU port, host port and RAM port of the arbiter.
// slave  : arbiter view (requests and RAM read data in, grants/RAM controls out)
// master : environment view (requesters and RAM model)
interface dm_port_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
);
  // CPU port
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  // Host port
  logic          h_req;
  logic          h_we;
  logic          h_lock;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;
  // RAM port
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  h_req, h_we, h_lock, h_addr, h_wdata,
    input  m_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output m_we, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output h_req, h_we, h_lock, h_addr, h_wdata,
    output m_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/dm_arb_wait_cnt.sv
// Saturating count of consecutive cycles the CPU has been refused.
// clk, rst_n : clock, async active-low reset
// clr_i      : clear (CPU granted or not requesting)
// inc_i      : increment, saturating at MaxWait
// at_max_o   : count equals MaxWait
module dm_arb_wait_cnt #(
  parameter int unsigned MaxWait = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [7:0] MaxCnt = 8'(MaxWait);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i && cnt_q != MaxCnt) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates a single-port synchronous-read data RAM between the CPU
// load/store path and a host/debug loader. Round-robin on contention,
// host burst lock, bounded by a CPU starvation limit.
// clk, rst_n : clock, async active-low reset
// bus_io     : CPU request/grant/read-data port, host port, RAM port
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW       = DefAw,
  parameter int unsigned DW       = DefDw,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic                clk,
  input logic                rst_n,
  dm_port_arbiter_if.slave   bus_io
);

  owner_e last_own_q, last_own_d;
  logic   h_lock_q, h_lock_d;
  logic   pend_valid_q, pend_valid_d;
  owner_e pend_own_q, pend_own_d;

  logic   starve, at_max;
  grant_t grant;
  logic   c_gnt, h_gnt, gnt_we;

  dm_arb_wait_cnt #(
    .MaxWait (MAX_WAIT)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (c_gnt || !bus_io.c_req),
    .inc_i    (bus_io.c_req && !c_gnt),
    .at_max_o (at_max)
  );

  assign starve = bus_io.c_req && at_max;
  assign grant  = arb_pick(bus_io.c_req, bus_io.h_req, starve, last_own_q, h_lock_q);
  assign c_gnt  = grant.gnt && (grant.own == OWN_CPU);
  assign h_gnt  = grant.gnt && (grant.own == OWN_HOST);

  assign bus_io.c_gnt = c_gnt;
  assign bus_io.h_gnt = h_gnt;

  // RAM port follows the granted requester; idle bus is all zero.
  always_comb begin
    bus_io.m_we    = 1'b0;
    bus_io.m_addr  = '0;
    bus_io.m_wdata = '0;
    if (c_gnt) begin
      bus_io.m_we    = bus_io.c_we;
      bus_io.m_addr  = bus_io.c_addr;
      bus_io.m_wdata = bus_io.c_wdata;
    end else if (h_gnt) begin
      bus_io.m_we    = bus_io.h_we;
      bus_io.m_addr  = bus_io.h_addr;
      bus_io.m_wdata = bus_io.h_wdata;
    end
  end

  assign gnt_we = c_gnt ? bus_io.c_we : bus_io.h_we;

  always_comb begin
    last_own_d   = last_own_q;
    h_lock_d     = h_lock_q;
    pend_valid_d = 1'b0;
    pend_own_d   = pend_own_q;
    if (grant.gnt) begin
      last_own_d   = grant.own;
      pend_valid_d = !gnt_we;
      pend_own_d   = grant.own;
    end
    // Lock only survives an uninterrupted run of host grants.
    if (h_gnt) begin
      h_lock_d = bus_io.h_lock;
    end else if (c_gnt) begin
      h_lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_own_q   <= OWN_HOST;
      h_lock_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_own_q   <= OWN_CPU;
    end else begin
      last_own_q   <= last_own_d;
      h_lock_q     <= h_lock_d;
      pend_valid_q <= pend_valid_d;
      pend_own_q   <= pend_own_d;
    end
  end

  assign bus_io.c_rvalid = pend_valid_q && (pend_own_q == OWN_CPU);
  assign bus_io.h_rvalid = pend_valid_q && (pend_own_q == OWN_HOST);
  assign bus_io.c_rdata  = bus_io.c_rvalid ? bus_io.m_rdata : '0;
  assign bus_io.h_rdata  = bus_io.h_rvalid ? bus_io.m_rdata : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  typedef struct {
    logic          host;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  rd_t           sb[$];
  logic [DW-1:0] shadow[64];
  logic [DW-1:0] ram[64];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always #5 clk = ~clk;

  dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_port_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  // Synchronous-read RAM model with a preload port used only during reset.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.m_we) ram[bus.m_addr] <= bus.m_wdata;
    bus.m_rdata <= ram[bus.m_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic hr, input logic hw,
                       input logic hl, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.h_req = hr; bus.h_we = hw; bus.h_lock = hl; bus.h_addr = ha; bus.h_wdata = hd;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":c_gnt"}, 32'(bus.c_gnt), 32'd0);
    check({tag, ":h_gnt"}, 32'(bus.h_gnt), 32'd0);
    check({tag, ":c_rvalid"}, 32'(bus.c_rvalid), 32'd0);
    check({tag, ":h_rvalid"}, 32'(bus.h_rvalid), 32'd0);
    check({tag, ":c_rdata"}, bus.c_rdata, 32'd0);
    check({tag, ":h_rdata"}, bus.h_rdata, 32'd0);
    check({tag, ":m_we"}, 32'(bus.m_we), 32'd0);
    check({tag, ":m_addr"}, 32'(bus.m_addr), 32'd0);
    check({tag, ":m_wdata"}, bus.m_wdata, 32'd0);
  endtask

  // One clock cycle: check read data from the previous grant, drive the
  // request, check the grant and RAM controls, record the expected result.
  task automatic step(input string tag,
                      input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input logic hr, input logic hw,
                      input logic hl, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                      input logic ec, input logic eh);
    rd_t  e;
    logic have;
    logic ecv, ehv;
    @(negedge clk);
    have = (sb.size() > 0);
    e.host = 1'b0;
    e.data = '0;
    if (have) e = sb.pop_front();
    ecv = have && !e.host;
    ehv = have && e.host;
    check({tag, ":c_rvalid"}, 32'(bus.c_rvalid), 32'(ecv));
    check({tag, ":h_rvalid"}, 32'(bus.h_rvalid), 32'(ehv));
    check({tag, ":c_rdata"}, bus.c_rdata, ecv ? e.data : 32'd0);
    check({tag, ":h_rdata"}, bus.h_rdata, ehv ? e.data : 32'd0);
    drive(cr, cw, ca, cd, hr, hw, hl, ha, hd);
    #1;
    check({tag, ":c_gnt"}, 32'(bus.c_gnt), 32'(ec));
    check({tag, ":h_gnt"}, 32'(bus.h_gnt), 32'(eh));
    if (ec) begin
      check({tag, ":m_we"}, 32'(bus.m_we), 32'(cw));
      check({tag, ":m_addr"}, 32'(bus.m_addr), 32'(ca));
      if (cw) shadow[ca] = cd;
      else sb.push_back('{host: 1'b0, data: shadow[ca]});
    end else if (eh) begin
      check({tag, ":m_we"}, 32'(bus.m_we), 32'(hw));
      check({tag, ":m_addr"}, 32'(bus.m_addr), 32'(ha));
      if (hw) shadow[ha] = hd;
      else sb.push_back('{host: 1'b1, data: shadow[ha]});
    end else begin
      check({tag, ":m_we"}, 32'(bus.m_we), 32'd0);
      check({tag, ":m_addr"}, 32'(bus.m_addr), 32'd0);
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
    #1;
    check_zero(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
    #1;
    check_zero("reset");
    // Preload RAM and shadow while reset is held.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = AW'(i);
      pre_data = (i == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + 32'(i) * 32'h0101;
      shadow[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    rst_n  = 1'b1;

    // CPU read straight after reset.
    step("rd5", 1, 0, 6'd5, '0, 0, 0, 0, '0, '0, 1, 0);
    idle("rd5_data");

    // Continuous contention without lock: CPU wins first tie, then alternate.
    do_reset("reset2");
    step("rr0", 1, 0, 6'd9, '0, 1, 0, 0, 6'd7, '0, 1, 0);
    step("rr1", 1, 0, 6'd9, '0, 1, 0, 0, 6'd7, '0, 0, 1);
    step("rr2", 1, 0, 6'd9, '0, 1, 0, 0, 6'd7, '0, 1, 0);
    step("rr3", 1, 0, 6'd9, '0, 1, 0, 0, 6'd7, '0, 0, 1);
    idle("rr_drain");

    // Host write then CPU readback.
    step("hwr3", 0, 0, '0, '0, 1, 1, 0, 6'd3, 32'h1234_5678, 0, 1);
    step("crd3", 1, 0, 6'd3, '0, 0, 0, 0, '0, '0, 1, 0);
    idle("crd3_data");

    // Locked host burst; CPU starved MW cycles, then round-robin resumes.
    step("lk_open", 0, 0, '0, '0, 1, 1, 1, 6'd10, 32'hA000_0010, 0, 1);
    for (int i = 0; i < MW; i++)
      step("lk_burst", 1, 0, 6'd3, '0, 1, 1, 1, AW'(11 + i), 32'hA000_0000 + 32'(i), 0, 1);
    step("lk_starve", 1, 0, 6'd3, '0, 1, 1, 0, 6'd15, 32'hA000_0015, 1, 0);
    step("lk_rr_h", 0, 0, '0, '0, 1, 1, 0, 6'd15, 32'hA000_0015, 0, 1);
    step("lk_rr_c", 1, 0, 6'd12, '0, 1, 0, 0, 6'd13, '0, 1, 0);
    step("lk_rr_h2", 0, 0, '0, '0, 1, 0, 0, 6'd13, '0, 0, 1);
    idle("lk_drain");

    // CPU withdraws after 3 refusals; bound restarts from the new request.
    step("wr_open", 0, 0, '0, '0, 1, 1, 1, 6'd20, 32'h5555_AAAA, 0, 1);
    for (int i = 0; i < 3; i++)
      step("wr_pre", 1, 0, 6'd20, '0, 1, 1, 1, AW'(21 + i), 32'hB000_0000 + 32'(i), 0, 1);
    step("wr_drop", 0, 0, '0, '0, 1, 1, 1, 6'd24, 32'hB000_0024, 0, 1);
    for (int i = 0; i < MW; i++)
      step("wr_post", 1, 0, 6'd20, '0, 1, 1, 1, AW'(25 + i), 32'hB000_0100 + 32'(i), 0, 1);
    step("wr_starve", 1, 0, 6'd20, '0, 1, 1, 0, 6'd29, 32'hB000_0029, 1, 0);
    step("wr_host", 0, 0, '0, '0, 1, 1, 0, 6'd29, 32'hB000_0029, 0, 1);
    idle("wr_drain");

    // Reset asserted while a read result is pending.
    step("rst_rd", 1, 0, 6'd5, '0, 0, 0, 0, '0, '0, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    idle("rst_after");
    step("post_rst", 1, 0, 6'd3, '0, 0, 0, 0, '0, '0, 1, 0);
    idle("post_rst_data");

    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrates the single-port 32-bit data memory between two requesters: the multi-cycle RV32I core's load/store path and a host/debug loader port. It sits between the core's memory interface and the data RAM, a synchronous-read block RAM with word address and one-cycle read latency. The arbiter uses round-robin on contention and a host burst lock, bounded by a CPU starvation limit. It returns read data to whichever requester owned the access.

## Interface
Parameters:
- AW, 6, word-address width (RAM addressed by byte address [AW+1:2])
- DW, 32, data width
- MAX_WAIT, 8, max consecutive cycles the CPU may be refused while the host holds a lock (1..255)

Ports:
- clk  in  1  the single clock; everything samples on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- c_req / c_we  in  1 / 1  CPU request, write enable
- c_addr / c_wdata  in  AW / DW  CPU word address, write data
- c_gnt  out  1  CPU access accepted this cycle
- c_rvalid / c_rdata  out  1 / DW  CPU read data valid, data
- h_req / h_we / h_lock  in  1 / 1 / 1  host request, write enable, burst lock
- h_addr / h_wdata  in  AW / DW  host word address, write data
- h_gnt / h_rvalid / h_rdata  out  1 / 1 / DW  host grant, read valid, read data
- m_we  out  1  RAM write enable
- m_addr / m_wdata  out  AW / DW  RAM address, write data
- m_rdata  in  DW  RAM read data, valid one cycle after the address edge

## Operation
- Requesters hold req and all request fields stable until they see gnt. The access is performed on the edge where gnt=1.
- At most one gnt per cycle. m_we/m_addr/m_wdata come from the granted requester (combinational). With no grant: m_we=0, m_addr=0, m_wdata=0.
- Grant decision, in priority order:
  1. starve: c_req && wait_cnt==MAX_WAIT -> CPU.
  2. lock: last owner=HOST && h_lock_q && h_req -> HOST.
  3. only one req -> that requester.
  4. both req -> requester that is not the last owner (round-robin).
- last owner register updates only on a grant. It resets to HOST, so the CPU wins the first tie.
- h_lock_q is h_lock registered on a host grant and cleared on any CPU grant. The lock only extends an ongoing host run.
- wait_cnt, 8-bit:
  - clears when c_gnt or !c_req;
  - otherwise increments, saturating at MAX_WAIT.
- Read (gnt && !we): pend_valid<=1, pend_own<=owner. Next cycle the owner's rvalid=1 and rdata=m_rdata; the other port's rdata=0.
- Writes produce no rvalid. A write grant clears pend_valid.
- Back-to-back reads by either port are allowed every cycle. pend is overwritten each edge.

## Timing
- Reset (async assert):
  - c_gnt=h_gnt=0 (no req while reset held);
  - c_rvalid=h_rvalid=0, c_rdata=h_rdata=0;
  - wait_cnt=0, h_lock_q=0, pend_valid=0, last owner=HOST.
- Grant latency: 0 cycles (combinational from req + state). Read data latency: exactly 1 cycle after the grant edge.
- Reset asserted mid-read: the pending rvalid is dropped and never issued.
- Requester drops req without gnt: legal, no access, wait_cnt clears.
- Starvation bound: a continuously requesting CPU is granted no later than MAX_WAIT+1 cycles after req rises.
- Simultaneous starve and lock: starve wins. The CPU grant clears h_lock_q.

## Structure
- Shared package dm_arb_pkg: owner enum {OWN_CPU=1'b0, OWN_HOST=1'b1}, default AW/DW constants.
- One sub-module: dm_arb_wait_cnt, the saturating starvation counter with clear/inc/at_max.
- Arbiter core: pure next-owner combinational function plus registers for last owner, h_lock_q, pend_valid, pend_own.

## Test plan
- Reset release, CPU read addr 5 (RAM[5]=0xDEADBEEF): c_gnt same cycle; next cycle c_rvalid=1, c_rdata=0xDEADBEEF; h_rvalid=0.
- Both request every cycle, no lock: grants alternate CPU, HOST, CPU, HOST; first grant goes to CPU.
- Host write 0x12345678 to addr 3, then CPU read addr 3: no rvalid after the write; the CPU read returns 0x12345678.
- Host h_lock=1 burst, CPU requesting from cycle 0, MAX_WAIT=4: host granted 4 cycles, CPU granted on the 5th, then round-robin resumes.
- Read granted, rst_n pulsed low before the next edge: no rvalid on either port; all outputs 0 during reset.
- CPU drops c_req after 3 refused cycles, then re-requests: wait_cnt restarts at 0, so the starvation bound is measured from the new request.
